mxn_rr: RTL

MXN_RR -- requirements
Module: mxn_rr

---
 rtl/mxn_pkg.sv | 15 +
 rtl/mxn_rr_if.sv | 28 ++
 rtl/mxn_rr_arb.sv | 60 ++++++
 rtl/mxn_rr.sv | 108 ++++++++++
 4 files changed

// File: rtl/mxn_pkg.sv
// Shared constants and encodings for the mxn_rr channel multiplexer.
package mxn_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_NCH   = 8;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_e;

endpackage

// File: rtl/mxn_rr_if.sv
// Channel-side and output-side handshake bundle of mxn_rr.
interface mxn_rr_if
    import mxn_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH
);
    localparam int unsigned SW = $clog2(NCH);

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SW-1:0]        out_ch;
    logic                 out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/mxn_rr_arb.sv
// rr_arb: fixed-select or wrap-around round-robin grant with the last-granted pointer.
module rr_arb
    import mxn_pkg::*;
#(
    parameter  int unsigned NCH = DEF_NCH,
    localparam int unsigned SW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [NCH-1:0] req,
    input  logic           take_en,
    output logic [NCH-1:0] grant_c,
    output logic [SW-1:0]  grant_idx_c,
    output logic           grant_vld_c
);
    localparam int unsigned NPOW = 1 << SW;

    logic [SW-1:0]   ptr_q, ptr_d;
    logic [NPOW-1:0] req_pad;
    logic [SW-1:0]   cand;

    // Zero-padded request vector so indices >= NCH read as "not valid".
    always_comb req_pad = NPOW'(req);

    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand        = ptr_q;
        if (mode == MODE_FIXED) begin
            grant_vld_c = req_pad[sel];
            grant_idx_c = sel;
        end else begin
            // Walk ptr+1 .. NCH-1, 0 .. ptr; first hit wins, ptr itself is last.
            for (int unsigned k = 0; k < NCH; k++) begin
                if (cand == SW'(NCH - 1)) cand = '0;
                else                      cand = cand + 1'b1;
                if (!grant_vld_c && req_pad[cand]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = cand;
                end
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            grant_c[i] = grant_vld_c && (grant_idx_c == SW'(i));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (take_en && grant_vld_c) ptr_d = grant_idx_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= SW'(NCH - 1);
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mxn_rr.sv
// mxn_rr: NCH-to-1 channel multiplexer with a one-word output register.
// Optional MXN_RR_STAT_EN adds grant_cnt, a count of completed output transfers.
module mxn_rr
    import mxn_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned NCH   = DEF_NCH,
    localparam int unsigned SW    = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    mxn_rr_if.slave       bus
`ifdef MXN_RR_STAT_EN
    ,
    output logic [15:0]   grant_cnt
`endif
);
    ostate_e          state_q, state_d;
    logic             out_valid_c;
    logic             load_en_c;
    logic             take_c;
    logic [NCH-1:0]   grant_c;
    logic [SW-1:0]    grant_idx_c;
    logic             grant_vld_c;
    logic [WIDTH-1:0] mux_data_c;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_ch_q, out_ch_d;

    rr_arb #(.NCH(NCH)) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .sel         (sel),
        .req         (bus.in_valid),
        .take_en     (load_en_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .grant_vld_c (grant_vld_c)
    );

    always_comb begin
        load_en_c = (state_q == EMPTY) || bus.out_ready;
        take_c    = load_en_c && grant_vld_c;
    end

    always_comb begin
        mux_data_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_idx_c == SW'(i)) mux_data_c = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output-stage FSM: register, next state, outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (load_en_c) state_d = take_c ? FULL : EMPTY;
    end

    always_comb begin
        out_valid_c = (state_q == FULL);
    end

    always_comb begin
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        if (take_c) begin
            out_data_d = mux_data_c;
            out_ch_d   = grant_idx_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q <= '0;
            out_ch_q   <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
        end
    end

    // reset_n gates in_ready so it drops the moment reset asserts.
    assign bus.in_ready  = grant_c & {NCH{load_en_c & reset_n}};
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

`ifdef MXN_RR_STAT_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb grant_cnt_d = grant_cnt_q + 16'(out_valid_c && bus.out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) grant_cnt_q <= '0;
        else          grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule
